// File: rtl/regression_pkg.sv
// Shared state encoding and fixed-point helpers for the regression solver.
// Helpers work on a wide signed carrier so they serve any WIDTH up to 64.
package regression_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_PIVOT, S_SWAP, S_RECIP, S_NORM, S_ELIM, S_BACK, S_OUT
   } state_t;

   localparam int MAX_W     = 64;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_FRAC  = 16;

   typedef logic signed [2*MAX_W-1:0] wide_t;

   function automatic wide_t fx_one(input int frac);
      return wide_t'(1) <<< frac;
   endfunction

   function automatic wide_t fx_max(input int width);
      return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t fx_min(input int width);
      return -(wide_t'(1) <<< (width - 1));
   endfunction

   function automatic wide_t sat(input wide_t v, input int width);
      wide_t hi;
      wide_t lo;
      hi = fx_max(width);
      lo = fx_min(width);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Full-precision product, floor-shifted back to the Q format, then clamped.
   function automatic wide_t fx_mul(input wide_t a, input wide_t b, input int width,
                                    input int frac);
      wide_t p;
      p = a * b;
      return sat(p >>> frac, width);
   endfunction

endpackage

// File: rtl/fx_recip_pipe.sv
// Pipelined saturated fixed-point reciprocal: recip = 1.0/den after DIV_LATENCY cycles.
// A start pulse travels down a valid chain alongside the quotient.
module fx_recip_pipe
   import regression_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int FRAC        = 16,
   parameter int DIV_LATENCY = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] den,
   output logic                    valid,
   output logic signed [WIDTH-1:0] recip
);

   logic [DIV_LATENCY:1]    vld_pipe;
   logic signed [WIDTH-1:0] q_pipe [1:DIV_LATENCY];
   logic signed [WIDTH-1:0] quot;

   // A zero divisor never reaches a valid result; the guard only keeps the datapath defined.
   always_comb begin
      quot = WIDTH'(fx_max(WIDTH));
      if (den != '0)
         quot = WIDTH'(sat((wide_t'(1) <<< (2 * FRAC)) / wide_t'(den), WIDTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= (vld_pipe << 1) | DIV_LATENCY'(start);
   end

   always_ff @(posedge clk) begin
      q_pipe[1] <= quot;
      for (int s = 2; s <= DIV_LATENCY; s++) q_pipe[s] <= q_pipe[s-1];
   end

   assign valid = vld_pipe[DIV_LATENCY];
   assign recip = q_pipe[DIV_LATENCY];

endmodule

// File: rtl/solve_regression_nxn.sv
// N x N fixed-point solver: partial-pivot Gaussian elimination, then back-substitution.
// One shared multiplier and one reciprocal per pivot; singular systems return beta = 0.
module solve_regression_nxn
   import regression_pkg::*;
#(
   parameter int N           = 3,
   parameter int WIDTH       = 32,
   parameter int FRAC        = 16,
   parameter int MUL_LATENCY = 2,
   parameter int DIV_LATENCY = 3,
   parameter int EPS         = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N*N-1:0][WIDTH-1:0] a_flat,
   input  logic [N-1:0][WIDTH-1:0]   b_flat,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N-1:0][WIDTH-1:0]   beta,
   output logic                      singular,
   output logic                      busy
);

   localparam int IW = $clog2(N + 1);
   localparam int AW = WIDTH + 4;
   typedef logic [IW-1:0] idx_t;
   localparam idx_t                    LAST    = idx_t'(N - 1);
   localparam idx_t                    RHS     = idx_t'(N);
   localparam logic signed [WIDTH-1:0] W_ONE   = WIDTH'(fx_one(FRAC));
   localparam logic signed [WIDTH-1:0] W_MAX   = WIDTH'(fx_max(WIDTH));
   localparam logic signed [WIDTH-1:0] W_MIN   = WIDTH'(fx_min(WIDTH));

   state_t                  state;
   logic signed [WIDTH-1:0] aug [N][N+1];
   idx_t                    k, r, i, j, best;
   logic [WIDTH-1:0]        best_abs, cand_abs;
   logic signed [WIDTH-1:0] cand, recip_q, factor;
   logic signed [AW-1:0]    acc;
   logic                    pend;

   // shared multiplier
   logic                    mul_issue, mul_done;
   logic signed [WIDTH-1:0] mul_x, mul_y, mul_res, elim_val;
   logic [MUL_LATENCY:1]    vld_pipe;
   logic signed [WIDTH-1:0] mul_pipe [1:MUL_LATENCY];

   logic                    rcp_start, rcp_valid;
   logic signed [WIDTH-1:0] rcp_out;

   always_comb begin
      mul_issue = 1'b0;
      mul_x     = '0;
      mul_y     = '0;
      case (state)
         S_NORM: begin
            mul_issue = !pend;
            mul_x     = aug[k][j];
            mul_y     = recip_q;
         end
         S_ELIM: begin
            mul_issue = !pend;
            mul_x     = (j == k) ? aug[i][k] : factor;
            mul_y     = aug[k][j];
         end
         S_BACK: begin
            // the j == i slot multiplies zero; it only paces the row write-back
            mul_issue = !pend;
            if (j != i) begin
               mul_x = aug[i][j];
               mul_y = $signed(beta[j]);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= (vld_pipe << 1) | MUL_LATENCY'(mul_issue);
   end

   always_ff @(posedge clk) begin
      mul_pipe[1] <= WIDTH'(fx_mul(wide_t'(mul_x), wide_t'(mul_y), WIDTH, FRAC));
      for (int s = 2; s <= MUL_LATENCY; s++) mul_pipe[s] <= mul_pipe[s-1];
   end

   assign mul_done = vld_pipe[MUL_LATENCY];
   assign mul_res  = mul_pipe[MUL_LATENCY];
   assign elim_val = WIDTH'(sat(wide_t'(aug[i][j]) - wide_t'(mul_res), WIDTH));

   // |most-negative| has no positive twin, so it clamps to the largest magnitude
   always_comb begin
      cand = aug[r][k];
      if (cand == W_MIN)    cand_abs = W_MAX;
      else if (cand < 0)    cand_abs = -cand;
      else                  cand_abs = cand;
   end

   assign rcp_start = (state == S_RECIP) && !pend;

   fx_recip_pipe #(
      .WIDTH       (WIDTH),
      .FRAC        (FRAC),
      .DIV_LATENCY (DIV_LATENCY)
   ) u_recip (
      .clk   (clk),
      .rst_n (rst_n),
      .start (rcp_start),
      .den   (aug[k][k]),
      .valid (rcp_valid),
      .recip (rcp_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         singular  <= 1'b0;
         beta      <= '0;
         k         <= '0;
         r         <= '0;
         i         <= '0;
         j         <= '0;
         best      <= '0;
         best_abs  <= '0;
         recip_q   <= '0;
         factor    <= '0;
         acc       <= '0;
         pend      <= 1'b0;
      end else begin
         if (mul_issue || rcp_start) pend <= 1'b1;
         case (state)
            S_IDLE: if (in_valid) begin
               for (int ii = 0; ii < N; ii++) begin
                  for (int jj = 0; jj < N; jj++) aug[ii][jj] <= a_flat[ii*N+jj];
                  aug[ii][N] <= b_flat[ii];
               end
               singular <= 1'b0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
               state    <= S_LOAD;
            end
            S_LOAD: begin
               k     <= '0;
               r     <= '0;
               state <= S_PIVOT;
            end
            S_PIVOT: begin
               if (r == k || cand_abs > best_abs) begin
                  best     <= r;
                  best_abs <= cand_abs;
               end
               if (r == LAST) state <= S_SWAP;
               else           r     <= r + 1'b1;
            end
            S_SWAP: begin
               for (int jj = 0; jj <= N; jj++) begin
                  aug[k][jj]    <= aug[best][jj];
                  aug[best][jj] <= aug[k][jj];
               end
               if (best_abs < WIDTH'(EPS)) begin
                  singular  <= 1'b1;
                  beta      <= '0;
                  out_valid <= 1'b1;
                  state     <= S_OUT;
               end else begin
                  state <= S_RECIP;
               end
            end
            S_RECIP: if (rcp_valid) begin
               pend       <= 1'b0;
               recip_q    <= rcp_out;
               aug[k][k]  <= W_ONE;
               j          <= k + 1'b1;
               state      <= S_NORM;
            end
            S_NORM: if (mul_done) begin
               pend      <= 1'b0;
               aug[k][j] <= mul_res;
               if (j != RHS) begin
                  j <= j + 1'b1;
               end else if (k == LAST) begin
                  i     <= LAST;
                  j     <= LAST;
                  state <= S_BACK;
               end else begin
                  i     <= k + 1'b1;
                  j     <= k;
                  state <= S_ELIM;
               end
            end
            S_ELIM: begin
               // factor must be the pre-elimination a[i][k]; the j == k slot overwrites it
               if (!pend && j == k) factor <= aug[i][k];
               if (mul_done) begin
                  pend      <= 1'b0;
                  aug[i][j] <= elim_val;
                  if (j != RHS) begin
                     j <= j + 1'b1;
                  end else if (i != LAST) begin
                     i <= i + 1'b1;
                     j <= k;
                  end else begin
                     k     <= k + 1'b1;
                     r     <= k + 1'b1;
                     state <= S_PIVOT;
                  end
               end
            end
            S_BACK: begin
               if (!pend && j == LAST) acc <= AW'(aug[i][N]);
               if (mul_done) begin
                  pend <= 1'b0;
                  if (j != i) begin
                     acc <= acc - AW'(mul_res);
                     j   <= j - 1'b1;
                  end else begin
                     beta[i] <= WIDTH'(sat(wide_t'(acc), WIDTH));
                     if (i == '0) begin
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                     end else begin
                        i <= i - 1'b1;
                        j <= LAST;
                     end
                  end
               end
            end
            S_OUT: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
